// File: rtl/vertex_stream_ctrl.sv
// Packs a 16+4 word stream into matmul a/b operands, waits out the core latency, streams x back.
// Latency: last vertex word accepted -> first out_valid is MM_LATENCY+2 cycles.
// Backpressure: in_ready only in LOAD states; DRAIN holds out_data until out_ready.
// Optional MATRIX_CACHE_EN: keeps mm_a across passes, mat_reload forces a fresh matrix load.
module vertex_stream_ctrl #(
    parameter int DATA_W     = 16,
    parameter int MAT_N      = 4,
    parameter int MM_LATENCY = 7
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef MATRIX_CACHE_EN
    input  logic                          mat_reload,
`endif
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    output logic [MAT_N*MAT_N*DATA_W-1:0] mm_a,
    output logic [MAT_N*DATA_W-1:0]       mm_b,
    input  logic [MAT_N*DATA_W-1:0]       mm_x,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_last,
    output logic                          busy
);

    localparam int A_WORDS = MAT_N * MAT_N;
    localparam int IDX_W   = $clog2(A_WORDS);
    localparam int BIDX_W  = $clog2(MAT_N);
    localparam int CNT_W   = $clog2(MM_LATENCY + 1);

    typedef enum logic [2:0] {
        ST_LOAD_A,
        ST_LOAD_B,
        ST_WAIT,
        ST_CAPTURE,
        ST_DRAIN
    } state_t;

    state_t                                 state_q, state_d;
    logic [IDX_W-1:0]                       idx_q, idx_d;
    logic [CNT_W-1:0]                       wait_q, wait_d;
    logic [A_WORDS-1:0][DATA_W-1:0]         a_q, a_d;
    logic [MAT_N-1:0][DATA_W-1:0]           b_q, b_d;
    logic [MAT_N-1:0][DATA_W-1:0]           x_q, x_d;
    logic                                   in_xfer;
    logic                                   out_xfer;
    logic                                   a_last;
    logic                                   b_last;
    state_t                                 drain_exit;

`ifdef MATRIX_CACHE_EN
    logic                                   reload_q, reload_d;
`endif

    assign a_last = (idx_q == IDX_W'(A_WORDS - 1));
    assign b_last = (idx_q == IDX_W'(MAT_N - 1));

    // in_ready is gated by rst so nothing is accepted while reset is held.
    assign in_ready  = rst && ((state_q == ST_LOAD_A) || (state_q == ST_LOAD_B));
    assign out_valid = (state_q == ST_DRAIN);
    assign out_last  = out_valid && b_last;
    assign out_data  = out_valid ? x_q[idx_q[BIDX_W-1:0]] : '0;
    assign busy      = (state_q == ST_WAIT) || (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
    assign mm_a      = a_q;
    assign mm_b      = b_q;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

`ifdef MATRIX_CACHE_EN
    // A pulse on the exit cycle itself still counts, so it is OR-ed in here.
    assign drain_exit = (reload_q || mat_reload) ? ST_LOAD_A : ST_LOAD_B;
`else
    assign drain_exit = ST_LOAD_A;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        a_d     = a_q;
        b_d     = b_q;
        x_d     = x_q;
`ifdef MATRIX_CACHE_EN
        reload_d = reload_q || mat_reload;
`endif
        case (state_q)
            ST_LOAD_A: begin
                if (in_xfer) begin
                    a_d[idx_q] = in_data;
                    if (a_last) begin
                        state_d = ST_LOAD_B;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_LOAD_B: begin
                if (in_xfer) begin
                    b_d[idx_q[BIDX_W-1:0]] = in_data;
                    if (b_last) begin
                        state_d = ST_WAIT;
                        idx_d   = '0;
                        wait_d  = CNT_W'(MM_LATENCY);
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_CAPTURE: begin
                x_d     = mm_x;
                idx_d   = '0;
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_xfer) begin
                    if (b_last) begin
                        state_d = drain_exit;
                        idx_d   = '0;
`ifdef MATRIX_CACHE_EN
                        if (drain_exit == ST_LOAD_A) begin
                            reload_d = 1'b0;
                        end
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD_A;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_LOAD_A;
            idx_q   <= '0;
            wait_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            a_q     <= a_d;
            b_q     <= b_d;
            x_q     <= x_d;
        end
    end

`ifdef MATRIX_CACHE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reload_q <= 1'b0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

endmodule
